// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Purpose  : Multi-cycle multiply/divide unit feeding the HI/LO register
//            file. Signed/unsigned 32x32->64 multiply and radix-2 restoring
//            divide with MIPS-style sign rules and divide-by-zero results.
// Revision : 1.0 - initial release
// ============================================================================
module mdu #(
   parameter int unsigned MUL_CYCLES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [1:0]  hilo_wen,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   localparam logic [4:0] C_MUL_LAST = 5'(MUL_CYCLES - 1);
   localparam logic [4:0] C_DIV_LAST = 5'd31;

   logic [1:0]  state_q, state_d;
   logic [4:0]  cnt_q,   cnt_d;
   logic [1:0]  op_q,    op_d;
   logic [31:0] a_q,     a_d;
   logic [31:0] b_q,     b_d;
   logic [31:0] dq_q,    dq_d;    // dividend magnitude shifting out, quotient shifting in
   logic [31:0] rem_q,   rem_d;   // partial remainder magnitude
   logic [31:0] hi_q,    hi_d;
   logic [31:0] lo_q,    lo_d;

   // Operand interpretation: op[0]=0 selects the signed flavour of either operation.
   logic        w_signed_op;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_b_mag;
   logic [63:0] w_product;
   logic        w_src_a_neg;
   logic [32:0] w_rem_shift;
   logic [32:0] w_rem_diff;
   logic        w_step_ok;
   logic [31:0] w_rem_next;
   logic [31:0] w_dq_next;
   logic [31:0] w_quot_fix;
   logic [31:0] w_rem_fix;

   // Shared datapath: sign-extended product and one restoring-division step.
   always_comb begin
      w_signed_op = ~op_q[0];
      w_a_neg     = w_signed_op & a_q[31];
      w_b_neg     = w_signed_op & b_q[31];
      w_b_mag     = w_b_neg ? (32'd0 - b_q) : b_q;
      // Sign-extending to 64 bits makes a plain 64-bit multiply give the
      // correct two's-complement product for both signed and unsigned ops.
      w_product   = {{32{w_a_neg}}, a_q} * {{32{w_b_neg}}, b_q};
      w_src_a_neg = ~op[0] & src_a[31];
      w_rem_shift = {rem_q, dq_q[31]};
      w_rem_diff  = w_rem_shift - {1'b0, w_b_mag};
      w_step_ok   = ~w_rem_diff[32];
      w_rem_next  = w_step_ok ? w_rem_diff[31:0] : w_rem_shift[31:0];
      w_dq_next   = {dq_q[30:0], w_step_ok};
      // Quotient truncates toward zero; remainder follows the dividend sign.
      w_quot_fix  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_dq_next) : w_dq_next;
      w_rem_fix   = w_a_neg ? (32'd0 - w_rem_next) : w_rem_next;
   end

   // Next-state logic for the controller and all datapath registers.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      dq_d    = dq_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               a_d     = src_a;
               b_d     = src_b;
               cnt_d   = 5'd0;
               dq_d    = w_src_a_neg ? (32'd0 - src_a) : src_a;
               rem_d   = 32'd0;
               state_d = op[1] ? S_DIV : S_MUL;
            end
         end
         S_MUL: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == C_MUL_LAST) begin
               hi_d    = w_product[63:32];
               lo_d    = w_product[31:0];
               state_d = S_FIN;
            end
         end
         S_DIV: begin
            cnt_d = cnt_q + 5'd1;
            dq_d  = w_dq_next;
            rem_d = w_rem_next;
            if (cnt_q == C_DIV_LAST) begin
               // Divide-by-zero bypasses sign correction so hi returns src_a unchanged.
               if (b_q == 32'd0) begin
                  hi_d = a_q;
                  lo_d = 32'hFFFF_FFFF;
               end else begin
                  hi_d = w_rem_fix;
                  lo_d = w_quot_fix;
               end
               state_d = S_FIN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A flush abandons whatever is in flight, including a start in IDLE,
      // and keeps the result registers from being overwritten.
      if (flush) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         op_q    <= 2'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         dq_q    <= 32'd0;
         rem_q   <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dq_q    <= dq_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Outputs: the write strobe is gated by flush in the same cycle.
   always_comb begin
      busy     = (state_q != S_IDLE);
      done     = (state_q == S_FIN) & ~flush;
      hilo_wen = {2{done}};
      hi_wdata = hi_q;
      lo_wdata = lo_q;
   end

endmodule
`default_nettype wire

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Parameters
REQ-001 SHALL provide MUL_CYCLES, default 2: number of cycles spent in state MUL (legal range 1..15).

Interface
REQ-002 SHALL have clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have resetn  input  1  synchronous, active-low reset.
REQ-004 SHALL have start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have src_a  input  32  multiplicand or dividend.
REQ-007 SHALL have src_b  input  32  multiplier or divisor.
REQ-008 SHALL have flush  input  1  exception or cancel; aborts any in-flight operation.
REQ-009 SHALL have busy  output  1  high whenever state is not IDLE; the pipeline stalls on it.
REQ-010 SHALL have done  output  1  one-cycle pulse when results are valid.
REQ-011 SHALL have hilo_wen  output  2  write enables to the HI/LO register file, [1]=HI, [0]=LO.
REQ-012 SHALL have hi_wdata  output  32  upper product half or remainder.
REQ-013 SHALL have lo_wdata  output  32  lower product half or quotient.

Function
REQ-014 SHALL implement the FSM states IDLE, MUL, DIV and FIN.
REQ-015 In IDLE, start=1 with flush=0 SHALL latch op, src_a and src_b, clear the cycle counter, and go to MUL (op[1]=0) or DIV (op[1]=1).
REQ-016 start SHALL be ignored in MUL, DIV and FIN; operands SHALL NOT be re-sampled while busy.
REQ-017 MUL SHALL last exactly MUL_CYCLES cycles, then go to FIN with the 64-bit product registered.
REQ-018 The MULT product SHALL be signed 32x32->64 and the MULTU product unsigned 32x32->64; hi_wdata=[63:32], lo_wdata=[31:0].
REQ-019 DIV SHALL perform one restoring-division step per cycle on operand magnitudes: 32 cycles (counter 0..31), then go to FIN.
REQ-020 DIV quotient SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign; sign correction is applied before FIN.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0x00000000 (wrap, no trap).
REQ-022 Divisor = 0 (DIV or DIVU) SHALL yield lo=0xFFFFFFFF and hi=src_a, with the full 32-cycle latency and no trap.
REQ-023 In FIN, done=1 and hilo_wen=2'b11 SHALL be asserted for exactly one cycle with valid data, and the next state SHALL be IDLE.
REQ-024 Outside FIN, done=0 and hilo_wen=2'b00 SHALL hold; hi_wdata and lo_wdata are don't-care there.
REQ-025 Latency from the accepting edge SHALL be: done high MUL_CYCLES+1 cycles later for multiply, and 33 cycles later for divide.
REQ-026 busy SHALL rise the cycle after the accepting edge and fall the cycle after FIN.
REQ-027 flush=1 in any state SHALL force IDLE at the next edge and discard partial results.
REQ-028 flush=1 during FIN SHALL combinationally gate done and hilo_wen to 0 in that cycle.
REQ-029 start and flush asserted in the same IDLE cycle SHALL leave the block in IDLE.
REQ-030 A new start SHALL be accepted in the first IDLE cycle after FIN (back-to-back throughput = latency + 1).

Reset
REQ-031 resetn=0 at a clock edge SHALL force IDLE, clear the counter and all internal operand and result registers, and drive busy=0, done=0, hilo_wen=0, hi_wdata=0 and lo_wdata=0.
REQ-032 resetn=0 mid-operation SHALL abandon it with no done pulse, and the reset SHALL take priority over flush and start.

Verification
REQ-033 MULT 0xFFFFFFFE x 0x00000003 (MUL_CYCLES=2) -> done 3 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFFA, hilo_wen=11.
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 DIV -7 / 2 -> done 33 cycles after accept, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2.
REQ-036 DIV by 0 with src_a=0x12345678 -> lo=0xFFFFFFFF, hi=0x12345678; DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-037 Flush at DIV cycle 10, then flush during FIN of a MULT -> no done and hilo_wen=00 in both cases, busy=0 next cycle, and the next start is accepted.
REQ-038 resetn low mid-DIV, and start held high during busy -> outputs return to 0 and the held start does not restart the operation until IDLE.
